// File: rtl/cub_activ_vec_if.sv
// Beat-level bus of the multi-lane activation unit: input beat + per-beat config, output beat, status.
interface cub_activ_vec_if #(
    parameter int LANES   = 4,
    parameter int DWID    = 32,
    parameter int SCALE_W = 16,
    parameter int QP_W    = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DWID-1:0]   in_data;
    logic [2:0]              in_mode;
    logic [DWID-1:0]         cfg_bias;
    logic [DWID-1:0]         cfg_min;
    logic [DWID-1:0]         cfg_max;
    logic [SCALE_W-1:0]      cfg_scale;
    logic [QP_W-1:0]         cfg_qp;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DWID-1:0]   out_data;
    logic                    mode_err;
    logic                    busy;

    modport master (
        output in_valid, in_data, in_mode, cfg_bias, cfg_min, cfg_max, cfg_scale, cfg_qp, out_ready,
        input  in_ready, out_valid, out_data, mode_err, busy
    );

    modport slave (
        input  in_valid, in_data, in_mode, cfg_bias, cfg_min, cfg_max, cfg_scale, cfg_qp, out_ready,
        output in_ready, out_valid, out_data, mode_err, busy
    );
endinterface

// File: rtl/cub_activ_vec.sv
// SIMD activation unit: bias/clamp, per-lane multiply, shift/saturate and mode select over a
// 3-stage stall-all pipeline with valid/ready on both sides.
module cub_activ_vec #(
    parameter int LANES   = 4,
    parameter int DWID    = 32,
    parameter int SCALE_W = 16,
    parameter int QP_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    cub_activ_vec_if.slave  bus
);
    localparam int AW = DWID + 1;
    localparam int BW = SCALE_W + 1;
    localparam int PW = DWID + SCALE_W + 1;

    localparam logic [2:0] MODE_PASS  = 3'd0;
    localparam logic [2:0] MODE_RELU  = 3'd1;
    localparam logic [2:0] MODE_PRELU = 3'd2;
    localparam logic [2:0] MODE_CLIP  = 3'd3;
    localparam logic [2:0] MODE_HSIG  = 3'd4;
    localparam logic [2:0] MODE_HSWSH = 3'd5;

    localparam logic signed [DWID-1:0] SAT_HI  = (DWID'(1) << SCALE_W) - DWID'(1);
    localparam logic signed [DWID-1:0] SAT_LO  = ~SAT_HI;
    localparam logic signed [DWID-1:0] DATA_HI = {1'b0, {(DWID-1){1'b1}}};
    localparam logic signed [DWID-1:0] DATA_LO = {1'b1, {(DWID-1){1'b0}}};

    logic                s1_v_q, s2_v_q, s3_v_q, s3_err_q;
    logic [2:0]          s1_mode_q, s2_mode_q;
    logic [SCALE_W-1:0]  s1_scale_q;
    logic [QP_W-1:0]     s1_qp_q, s2_qp_q;
    logic                adv;
    logic [LANES*DWID-1:0] out_data_d;

    // Whole pipe moves only when the output slot is free or being drained.
    assign adv          = !s3_v_q || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = s3_v_q;
    assign bus.out_data  = out_data_d;
    assign bus.mode_err  = s3_v_q && s3_err_q && bus.out_ready;
    assign bus.busy      = s1_v_q || s2_v_q || s3_v_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            s3_v_q   <= 1'b0;
            s3_err_q <= 1'b0;
        end else if (adv) begin
            s1_v_q   <= bus.in_valid;
            s2_v_q   <= s1_v_q;
            s3_v_q   <= s2_v_q;
            s3_err_q <= s2_mode_q[2] & s2_mode_q[1];
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_mode_q  <= bus.in_mode;
            s1_scale_q <= bus.cfg_scale;
            s1_qp_q    <= bus.cfg_qp;
            s2_mode_q  <= s1_mode_q;
            s2_qp_q    <= s1_qp_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [DWID-1:0] x_d;
            logic signed [AW-1:0]   a_d, min_d, max_d;
            logic signed [DWID-1:0] c_d;
            logic signed [DWID-1:0] x1_q, c1_q;
            logic signed [DWID-1:0] mul_a_d;
            logic signed [BW-1:0]   csat_d, mul_b_d;
            logic signed [PW-1:0]   p_d;
            logic signed [DWID-1:0] x2_q, c2_q;
            logic signed [PW-1:0]   p2_q, sh_d;
            logic signed [DWID-1:0] m_d, res_d, out_q;

            assign x_d   = bus.in_data[gi*DWID +: DWID];
            // One extra bit makes the bias add exact, so the clamp sees the true sum.
            assign a_d   = {x_d[DWID-1], x_d} + {bus.cfg_bias[DWID-1], bus.cfg_bias};
            assign min_d = {bus.cfg_min[DWID-1], bus.cfg_min};
            assign max_d = {bus.cfg_max[DWID-1], bus.cfg_max};

            always_comb begin
                c_d = a_d[DWID-1:0];
                if (a_d < min_d)
                    c_d = bus.cfg_min;
                else if (a_d > max_d)
                    c_d = bus.cfg_max;
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    x1_q <= x_d;
                    c1_q <= c_d;
                end
            end

            always_comb begin
                csat_d = c1_q[BW-1:0];
                if (c1_q > SAT_HI)
                    csat_d = SAT_HI[BW-1:0];
                else if (c1_q < SAT_LO)
                    csat_d = SAT_LO[BW-1:0];
            end

            assign mul_a_d = (s1_mode_q == MODE_HSIG) ? c1_q : x1_q;
            assign mul_b_d = (s1_mode_q == MODE_HSWSH) ? csat_d
                                                        : {s1_scale_q[SCALE_W-1], s1_scale_q};
            assign p_d = $signed({{(PW-DWID){mul_a_d[DWID-1]}}, mul_a_d})
                       * $signed({{(PW-BW){mul_b_d[BW-1]}}, mul_b_d});

            always_ff @(posedge clk) begin
                if (adv) begin
                    x2_q <= x1_q;
                    c2_q <= c1_q;
                    p2_q <= p_d;
                end
            end

            assign sh_d = p2_q >>> s2_qp_q;

            always_comb begin
                m_d = sh_d[DWID-1:0];
                if (!sh_d[PW-1] && (|sh_d[PW-2:DWID-1]))
                    m_d = DATA_HI;
                else if (sh_d[PW-1] && !(&sh_d[PW-2:DWID-1]))
                    m_d = DATA_LO;
            end

            always_comb begin
                res_d = x2_q;
                case (s2_mode_q)
                    MODE_PASS:  res_d = x2_q;
                    MODE_RELU:  res_d = x2_q[DWID-1] ? '0 : x2_q;
                    MODE_PRELU: res_d = x2_q[DWID-1] ? m_d : x2_q;
                    MODE_CLIP:  res_d = c2_q;
                    MODE_HSIG,
                    MODE_HSWSH: res_d = m_d;
                    default:    res_d = x2_q;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst)
                    out_q <= '0;
                else if (adv)
                    out_q <= res_d;
            end

            assign out_data_d[gi*DWID +: DWID] = out_q;
        end
    endgenerate
endmodule

// File: tb/tb_cub_activ_vec.sv
// Directed bench for cub_activ_vec: single beats per mode, a backpressured mixed-mode stream,
// reserved-mode error pulse and reset with beats in flight.
module tb_cub_activ_vec;
    localparam int NB = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cub_activ_vec_if #(.LANES(4), .DWID(32), .SCALE_W(16), .QP_W(5)) bus ();

    cub_activ_vec #(.LANES(4), .DWID(32), .SCALE_W(16), .QP_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0]   bm     [NB];
    logic [127:0] bd     [NB];
    logic [127:0] be     [NB];
    logic [31:0]  bbias  [NB];
    logic [31:0]  bmin   [NB];
    logic [31:0]  bmax   [NB];
    logic [15:0]  bscale [NB];
    logic [4:0]   bqp    [NB];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic set_beat(input int i, input logic [2:0] m, input logic [127:0] d,
                            input int bias, input int mn, input int mx,
                            input int scale, input int qp, input logic [127:0] e);
        bm[i] = m; bd[i] = d; be[i] = e;
        bbias[i] = bias; bmin[i] = mn; bmax[i] = mx;
        bscale[i] = 16'(scale); bqp[i] = 5'(qp);
    endtask

    task automatic drive(input int b);
        bus.in_valid  = 1'b1;
        bus.in_mode   = bm[b];
        bus.in_data   = bd[b];
        bus.cfg_bias  = bbias[b];
        bus.cfg_min   = bmin[b];
        bus.cfg_max   = bmax[b];
        bus.cfg_scale = bscale[b];
        bus.cfg_qp    = bqp[b];
    endtask

    task automatic run_single(input int b, input string tag);
        int lat;
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(b);
        #1;
        check({tag, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 10);
        check({tag, "_latency"}, lat, 3);
        check({tag, "_data"}, bus.out_data, be[b]);
        check({tag, "_mode_err"}, bus.mode_err, (b == 11) ? 1 : 0);
        $display("beat tag=%s mode=%0d in=%h out=%h lat=%0d", tag, bm[b], bd[b], bus.out_data, lat);
        @(negedge clk);
        check({tag, "_drained"}, {bus.out_valid, bus.mode_err}, 2'b00);
    endtask

    task automatic run_stream();
        int tx = 0;
        int rx = 0;
        int cyc = 0;
        bit hold = 0;
        bit full_seen = 0;
        logic [127:0] held = '0;
        while (rx < 8 && cyc < 200) begin
            @(negedge clk);
            bus.out_ready = ((cyc / 2) % 2 == 0);
            if (tx < 8) drive(tx);
            else bus.in_valid = 1'b0;
            #1;
            if (hold) begin
                check("stream_hold_valid", bus.out_valid, 1);
                check("stream_hold_data", bus.out_data, held);
            end
            check("stream_in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (bus.out_valid && !bus.out_ready && (tx - rx) == 3) begin
                check("stream_full_in_ready", bus.in_ready, 0);
                full_seen = 1;
            end
            hold = bus.out_valid && !bus.out_ready;
            held = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("stream_beat%0d", rx), bus.out_data, be[rx]);
                check("stream_mode_err", bus.mode_err, 0);
                $display("beat stream idx=%0d mode=%0d out=%h cyc=%0d", rx, bm[rx], bus.out_data, cyc);
                rx++;
            end
            if (bus.in_valid && bus.in_ready) tx++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("stream_count", rx, 8);
        check("stream_full_seen", full_seen, 1);
    endtask

    initial begin
        bit ghost;
        // idx mode data bias min max scale qp expected
        set_beat(0, 3'd0, pk(1, -2, 3, -4), 3, 0, 6, 32'h4000, 15, pk(1, -2, 3, -4));
        set_beat(1, 3'd1, pk(-5, 7, 0, 32'sh80000000), 3, 0, 6, 32'h4000, 15, pk(0, 7, 0, 0));
        set_beat(2, 3'd2, pk(-100, 100, -1, 0), 3, 0, 6, 32'h4000, 15, pk(-50, 100, -1, 0));
        set_beat(3, 3'd3, pk(10, -7, 2, 32'sh7FFFFFFF), 3, 0, 6, 32'h4000, 15, pk(6, 0, 5, 6));
        set_beat(4, 3'd4, pk(3, -3, 0, -10), 3, 0, 6, 32'h2AAB, 16, pk(1, 0, 0, 0));
        set_beat(5, 3'd5, pk(2, -4, 5, 0), 3, 0, 6, 32'h4000, 0, pk(10, 0, 30, 0));
        set_beat(6, 3'd0, pk(100, 200, 300, 400), 3, 0, 6, 32'h4000, 15, pk(100, 200, 300, 400));
        set_beat(7, 3'd1, pk(-1, 1, -2, 2), 3, 0, 6, 32'h4000, 15, pk(0, 1, 0, 2));
        set_beat(8, 3'd2, pk(32'sh80000000, 32'sh80000000, 5, 0), 3, 0, 6, 32'h8000, 0,
                 pk(32'sh7FFFFFFF, 32'sh7FFFFFFF, 5, 0));
        set_beat(9, 3'd3, pk(-1000, 0, 1000, 32'sh7FFFFFFF), 0, 42, 42, 32'h4000, 15, pk(42, 42, 42, 42));
        set_beat(10, 3'd3, pk(-100, 0, 3, 100), -5, -10, 10, 32'h4000, 15, pk(-10, -5, -2, 10));
        set_beat(11, 3'd6, pk(11, -22, 33, -44), 3, 0, 6, 32'h4000, 15, pk(11, -22, 33, -44));

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_data = '0; bus.in_mode = '0;
        bus.cfg_bias = '0; bus.cfg_min = '0; bus.cfg_max = '0; bus.cfg_scale = '0; bus.cfg_qp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_mode_err", bus.mode_err, 0);
        check("rst_out_data", bus.out_data, '0);
        check("rst_in_ready", bus.in_ready, 1);
        rst = 1'b0;

        run_single(1, "relu");
        run_single(2, "prelu");
        run_single(8, "prelu_sat");
        run_single(3, "clip");
        run_single(9, "clip_min_eq_max");
        run_single(10, "clip_neg");
        run_single(5, "hswish");
        run_single(4, "hsigmoid");
        run_single(0, "pass");

        run_stream();

        run_single(11, "reserved");

        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(6);
        @(negedge clk);
        drive(7);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("inflight_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_out_data", bus.out_data, '0);
        ghost = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) ghost = 1;
        end
        check("midrst_no_ghost", ghost, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
